// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with binary pointers, fill level, programmable almost flags,
// selectable FWFT / registered read, and sticky overflow/underflow error flags.
module sync_fifo_flags #(
    parameter int DATA_SIZE     = 256,
    parameter int ARRAY_SIZE    = 3,
    parameter int FWFT          = 1,
    parameter int AFULL_THRESH  = 6,
    parameter int AEMPTY_THRESH = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_SIZE-1:0]  wdata,
    input  logic                  winc,
    output logic                  wfull,
    output logic                  walmost_full,
    output logic [DATA_SIZE-1:0]  rdata,
    input  logic                  rinc,
    output logic                  rempty,
    output logic                  ralmost_empty,
    output logic                  rvalid,
    output logic [ARRAY_SIZE:0]   count,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  clr_err
);

    localparam int CW    = ARRAY_SIZE + 1;
    localparam int DEPTH = 1 << ARRAY_SIZE;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C = CW'(AFULL_THRESH);
    localparam logic [CW-1:0] AEMPT_C = CW'(AEMPTY_THRESH);

    logic [DATA_SIZE-1:0] mem [DEPTH];
    logic [CW-1:0]        wptr;
    logic [CW-1:0]        rptr;
    logic [CW-1:0]        count_nxt;
    logic                 wr_acc;
    logic                 rd_acc;

    // A read never passes a write through when full, and a write is never
    // visible to a same-cycle read when empty: acceptance uses current flags.
    assign wr_acc = winc && !wfull;
    assign rd_acc = rinc && !rempty;

    always_comb begin
        count_nxt = count;
        if (wr_acc && !rd_acc)
            count_nxt = count + 1'b1;
        else if (rd_acc && !wr_acc)
            count_nxt = count - 1'b1;
    end

    // Flags are registered from next-count so they always agree with count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr          <= '0;
            rptr          <= '0;
            count         <= '0;
            rempty        <= 1'b1;
            wfull         <= 1'b0;
            ralmost_empty <= 1'b1;
            walmost_full  <= 1'b0;
        end else begin
            if (wr_acc)
                wptr <= wptr + 1'b1;
            if (rd_acc)
                rptr <= rptr + 1'b1;
            count         <= count_nxt;
            rempty        <= (count_nxt == '0);
            wfull         <= (count_nxt == DEPTH_C);
            walmost_full  <= (count_nxt >= AFULL_C);
            ralmost_empty <= (count_nxt <= AEMPT_C);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc)
            mem[wptr[ARRAY_SIZE-1:0]] <= wdata;
    end

    // A new error event in the same cycle as clr_err keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (winc && wfull)
                overflow <= 1'b1;
            else if (clr_err)
                overflow <= 1'b0;
            if (rinc && rempty)
                underflow <= 1'b1;
            else if (clr_err)
                underflow <= 1'b0;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign rdata  = mem[rptr[ARRAY_SIZE-1:0]];
            assign rvalid = ~rempty;
        end else begin : g_reg
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rdata  <= '0;
                    rvalid <= 1'b0;
                end else begin
                    rvalid <= rd_acc;
                    if (rd_acc)
                        rdata <= mem[rptr[ARRAY_SIZE-1:0]];
                end
            end
        end
    endgenerate

    // Pointer MSBs only disambiguate wrap; occupancy is tracked by count.
    logic unused_ptr_msb;
    assign unused_ptr_msb = wptr[ARRAY_SIZE] ^ rptr[ARRAY_SIZE];

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Drives one FWFT and one registered-read FIFO with shared stimulus and checks
// both against a queue-based reference model and an rdata scoreboard.
module tb_sync_fifo_flags;

    localparam int DW    = 32;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] wdata;
    logic          winc, rinc, clr_err;

    logic [DW-1:0] rdata_f, rdata_r;
    logic          wfull_f, wfull_r, afull_f, afull_r;
    logic          rempty_f, rempty_r, aempty_f, aempty_r;
    logic          rvalid_f, rvalid_r;
    logic [3:0]    count_f, count_r;
    logic          ovf_f, ovf_r, udf_f, udf_r;

    sync_fifo_flags #(.DATA_SIZE(DW), .FWFT(1)) u_fwft (
        .clk(clk), .rst_n(rst_n), .wdata(wdata), .winc(winc), .wfull(wfull_f),
        .walmost_full(afull_f), .rdata(rdata_f), .rinc(rinc), .rempty(rempty_f),
        .ralmost_empty(aempty_f), .rvalid(rvalid_f), .count(count_f),
        .overflow(ovf_f), .underflow(udf_f), .clr_err(clr_err));

    sync_fifo_flags #(.DATA_SIZE(DW), .FWFT(0)) u_reg (
        .clk(clk), .rst_n(rst_n), .wdata(wdata), .winc(winc), .wfull(wfull_r),
        .walmost_full(afull_r), .rdata(rdata_r), .rinc(rinc), .rempty(rempty_r),
        .ralmost_empty(aempty_r), .rvalid(rvalid_r), .count(count_r),
        .overflow(ovf_r), .underflow(udf_r), .clr_err(clr_err));

    always #5 clk = ~clk;

    int            n_checks = 0;
    int            n_fail   = 0;
    bit            done     = 1'b0;

    // Reference model: stored words, sticky errors, expected registered reads.
    logic [DW-1:0] mq[$];
    logic [DW-1:0] exp0[$];
    bit            movf, mudf, mrv;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        exp0.delete();
        movf = 1'b0;
        mudf = 1'b0;
        mrv  = 1'b0;
    endtask

    task automatic model_step();
        bit full, empty, wa, ra;
        if (!rst_n) begin
            model_reset();
            return;
        end
        full  = (mq.size() == DEPTH);
        empty = (mq.size() == 0);
        wa    = winc && !full;
        ra    = rinc && !empty;
        movf  = (winc && full)  ? 1'b1 : (clr_err ? 1'b0 : movf);
        mudf  = (rinc && empty) ? 1'b1 : (clr_err ? 1'b0 : mudf);
        mrv   = ra;
        if (ra) exp0.push_back(mq.pop_front());
        if (wa) mq.push_back(wdata);
    endtask

    // Inputs change 1 time unit after a rising edge; the model steps on the edge.
    task automatic cyc(input bit w, input logic [DW-1:0] d, input bit r, input bit c);
        winc = w; wdata = d; rinc = r; clr_err = c;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic check_status(input string tag);
        int sz;
        sz = mq.size();
        chk({tag, "count_f"},  count_f,  sz);
        chk({tag, "count_r"},  count_r,  sz);
        chk({tag, "rempty_f"}, rempty_f, sz == 0);
        chk({tag, "rempty_r"}, rempty_r, sz == 0);
        chk({tag, "wfull_f"},  wfull_f,  sz == DEPTH);
        chk({tag, "wfull_r"},  wfull_r,  sz == DEPTH);
        chk({tag, "afull_f"},  afull_f,  sz >= 6);
        chk({tag, "afull_r"},  afull_r,  sz >= 6);
        chk({tag, "aempty_f"}, aempty_f, sz <= 1);
        chk({tag, "aempty_r"}, aempty_r, sz <= 1);
        chk({tag, "ovf_f"},    ovf_f,    movf);
        chk({tag, "ovf_r"},    ovf_r,    movf);
        chk({tag, "udf_f"},    udf_f,    mudf);
        chk({tag, "udf_r"},    udf_r,    mudf);
        chk({tag, "rvalid_f"}, rvalid_f, sz != 0);
    endtask

    // Monitor: status every falling edge; FWFT head vs model; registered
    // read data popped from the scoreboard whenever rvalid is presented.
    initial begin
        forever begin
            @(negedge clk);
            if (done) break;
            check_status("");
            if (mq.size() != 0)
                chk("rdata_f_head", rdata_f, mq[0]);
            chk("rvalid_r", rvalid_r, mrv);
            if (!rst_n)
                chk("rdata_r_rst", rdata_r, '0);
            if (rvalid_r) begin
                if (exp0.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL rdata_r_unexpected act=%0h exp=none t=%0t", rdata_r, $time);
                end else begin
                    chk("rdata_r", rdata_r, exp0.pop_front());
                end
            end else if (mrv && exp0.size() != 0) begin
                void'(exp0.pop_front());
            end
        end
    end

    initial begin
        rst_n = 1'b0; winc = 1'b0; rinc = 1'b0; clr_err = 1'b0; wdata = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Fill 0x01..0x08, overflow attempt, then full with winc+rinc together.
        for (int i = 1; i <= 8; i++) cyc(1'b1, DW'(i), 1'b0, 1'b0);
        cyc(1'b1, 32'h09, 1'b0, 1'b0);
        cyc(1'b1, 32'h99, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b1);
        cyc(1'b0, '0, 1'b0, 1'b0);

        // Drain past empty for underflow, then clear.
        repeat (8) cyc(1'b0, '0, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b1);

        // Single word, then pop.
        cyc(1'b1, 32'hA5, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);

        // Three words, four reads (last one underflows).
        cyc(1'b1, 32'h11, 1'b0, 1'b0);
        cyc(1'b1, 32'h22, 1'b0, 1'b0);
        cyc(1'b1, 32'h33, 1'b0, 1'b0);
        repeat (4) cyc(1'b0, '0, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b1);

        // Steady state at count 4 with simultaneous traffic across pointer wrap.
        for (int i = 0; i < 4; i++) cyc(1'b1, 32'h200 + DW'(i), 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) cyc(1'b1, 32'h300 + DW'(i), 1'b1, 1'b0);
        repeat (4) cyc(1'b0, '0, 1'b1, 1'b0);

        // Random traffic: write-heavy, read-heavy, then balanced.
        for (int ph = 0; ph < 3; ph++) begin
            for (int i = 0; i < 200; i++) begin
                int wp;
                wp = (ph == 0) ? 75 : (ph == 1) ? 25 : 50;
                cyc($urandom_range(0, 99) < wp, $urandom, $urandom_range(0, 99) < (100 - wp),
                    $urandom_range(0, 15) == 0);
            end
        end

        // Drain, fill to 5, then asynchronous reset between edges.
        repeat (10) cyc(1'b0, '0, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) cyc(1'b1, 32'h500 + DW'(i), 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0);
        repeat (5) cyc(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b1, 32'h600 + DW'(i), 1'b0, 1'b0);
        winc = 1'b0;
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check_status("async_");
        chk("async_rvalid_r", rvalid_r, 1'b0);
        chk("async_rdata_r",  rdata_r,  '0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        rst_n = 1'b1;

        // Post-reset traffic confirms the discarded words are gone.
        cyc(1'b1, 32'h77, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 100; i++)
            cyc($urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 1) == 1, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);

        done = 1'b1;
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
